// File: rtl/sa2_tile_scheduler.sv
// Tile scheduler for a 2x2 output-stationary systolic array: clear, feed K skewed operand beats, drain, return sums.
// Optional SA2_SCHED_PERF_EN adds saturating busy-cycle and completed-tile counters.
module sa2_tile_scheduler #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned C_WIDTH   = 32,
  parameter int unsigned AW        = 10,
  parameter int unsigned KW        = 10,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic [AW-1:0]          a_base,
  input  logic [AW-1:0]          b_base,
  output logic                   busy,
  output logic                   a_rd_en,
  output logic [AW-1:0]          a_addr,
  input  logic [2*WIDTH-1:0]     a_rdata,
  output logic                   b_rd_en,
  output logic [AW-1:0]          b_addr,
  input  logic [2*WIDTH-1:0]     b_rdata,
  output logic [2*WIDTH-1:0]     sa_act,
  output logic [2*WIDTH-1:0]     sa_weight,
  output logic                   sa_control,
  input  logic [4*C_WIDTH-1:0]   sa_c_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*C_WIDTH-1:0]   res_data
`ifdef SA2_SCHED_PERF_EN
  ,
  output logic [31:0]            perf_busy_cyc,
  output logic [15:0]            perf_tiles
`endif
);

  localparam int unsigned LW  = 2 * WIDTH;
  localparam int unsigned RW  = 4 * C_WIDTH;
  localparam int unsigned DCW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_OUT} state_t;

  state_t          state, next_state;
  logic [KW-1:0]   k_q, feed_cnt;
  logic [AW-1:0]   a_base_q, b_base_q;
  logic [DCW-1:0]  drain_cnt;
  logic            feed_last, drain_last;

  logic            busy_d, rd_en_d, ctrl_d, valid_d;
  logic [AW-1:0]   a_addr_d, b_addr_d;
  logic [RW-1:0]   res_d;

  // Skew path: rd_q marks read data returning this cycle; lower lane waits one more cycle.
  logic            rd_q;
  logic [WIDTH-1:0] act_lo_q, wgt_lo_q;

  assign feed_last  = (feed_cnt == k_q - KW'(1));
  assign drain_last = (drain_cnt == DCW'(DRAIN_CYC - 1));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_CLEAR;
      S_CLEAR: next_state = (k_q == '0) ? S_OUT : S_FEED;
      S_FEED:  if (feed_last) next_state = S_DRAIN;
      S_DRAIN: if (drain_last) next_state = S_OUT;
      S_OUT:   if (res_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic: next-cycle values of the registered outputs
  always_comb begin
    busy_d   = (next_state != S_IDLE);
    rd_en_d  = (next_state == S_FEED);
    ctrl_d   = (next_state == S_CLEAR);
    valid_d  = (next_state == S_OUT);
    a_addr_d = '0;
    b_addr_d = '0;
    res_d    = res_data;
    if (next_state == S_FEED) begin
      a_addr_d = (state == S_FEED) ? a_addr + AW'(1) : a_base_q;
      b_addr_d = (state == S_FEED) ? b_addr + AW'(1) : b_base_q;
    end
    if (state == S_CLEAR && next_state == S_OUT) res_d = '0;
    else if (state == S_DRAIN && drain_last)     res_d = sa_c_out;
  end

  // Registered outputs, tile parameters and counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy       <= 1'b0;
      a_rd_en    <= 1'b0;
      b_rd_en    <= 1'b0;
      sa_control <= 1'b0;
      res_valid  <= 1'b0;
      a_addr     <= '0;
      b_addr     <= '0;
      res_data   <= '0;
      k_q        <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      feed_cnt   <= '0;
      drain_cnt  <= '0;
    end else begin
      busy       <= busy_d;
      a_rd_en    <= rd_en_d;
      b_rd_en    <= rd_en_d;
      sa_control <= ctrl_d;
      res_valid  <= valid_d;
      a_addr     <= a_addr_d;
      b_addr     <= b_addr_d;
      res_data   <= res_d;
      if (state == S_IDLE && start) begin
        k_q      <= k_len;
        a_base_q <= a_base;
        b_base_q <= b_base;
      end
      feed_cnt  <= (state == S_FEED)  ? feed_cnt + KW'(1)   : '0;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DCW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q     <= 1'b0;
      act_lo_q <= '0;
      wgt_lo_q <= '0;
    end else begin
      rd_q     <= a_rd_en;
      act_lo_q <= rd_q ? a_rdata[WIDTH-1:0] : '0;
      wgt_lo_q <= rd_q ? b_rdata[WIDTH-1:0] : '0;
    end
  end

  // Upper lane goes straight from the returning read data; idle cycles are zero-padded.
  assign sa_act    = {(rd_q ? a_rdata[LW-1:WIDTH] : WIDTH'(0)), act_lo_q};
  assign sa_weight = {(rd_q ? b_rdata[LW-1:WIDTH] : WIDTH'(0)), wgt_lo_q};

`ifdef SA2_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_busy_cyc <= '0;
      perf_tiles    <= '0;
    end else begin
      if (busy && !(&perf_busy_cyc))                    perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (res_valid && res_ready && !(&perf_tiles))     perf_tiles    <= perf_tiles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa2_tile_scheduler.sv
// Scoreboard bench for sa2_tile_scheduler with operand buffers and a behavioural 2x2 array model.
module tb_sa2_tile_scheduler;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         start = 1'b0;
  logic [9:0]   k_len = '0;
  logic [9:0]   a_base = '0;
  logic [9:0]   b_base = '0;
  logic         busy, a_rd_en, b_rd_en, sa_control, res_valid;
  logic [9:0]   a_addr, b_addr;
  logic [15:0]  a_rdata = '0;
  logic [15:0]  b_rdata = '0;
  logic [15:0]  sa_act, sa_weight;
  logic [127:0] sa_c_out;
  logic         res_ready = 1'b1;
  logic [127:0] res_data;

  always #5 clk = ~clk;

  sa2_tile_scheduler dut (
    .clk(clk), .rstn(rstn), .start(start), .k_len(k_len), .a_base(a_base), .b_base(b_base),
    .busy(busy), .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
    .sa_act(sa_act), .sa_weight(sa_weight), .sa_control(sa_control), .sa_c_out(sa_c_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  // Operand buffers with one-cycle read latency
  logic [15:0] a_mem [1024];
  logic [15:0] b_mem [1024];
  always @(posedge clk) begin
    if (a_rd_en) a_rdata <= a_mem[a_addr];
    if (b_rd_en) b_rdata <= b_mem[b_addr];
  end

  // 2x2 output-stationary array: activations hop right, weights hop down
  logic [31:0] c00 = '0, c01 = '0, c10 = '0, c11 = '0;
  logic [7:0]  h0 = '0, h1 = '0, v0 = '0, v1 = '0;
  always @(posedge clk) begin
    if (sa_control) begin
      c00 <= '0; c01 <= '0; c10 <= '0; c11 <= '0;
      h0 <= '0; h1 <= '0; v0 <= '0; v1 <= '0;
    end else begin
      c00 <= c00 + 32'(sa_act[15:8]) * 32'(sa_weight[15:8]);
      c01 <= c01 + 32'(h0) * 32'(sa_weight[7:0]);
      c10 <= c10 + 32'(sa_act[7:0]) * 32'(v0);
      c11 <= c11 + 32'(h1) * 32'(v1);
      h0 <= sa_act[15:8]; h1 <= sa_act[7:0];
      v0 <= sa_weight[15:8]; v1 <= sa_weight[7:0];
    end
  end
  assign sa_c_out = {c00, c01, c10, c11};

  int vectors = 0;
  int errors  = 0;
  logic [127:0] exp_res_q [$];
  logic [19:0]  exp_addr_q [$];
  bit           addr_chk_en = 1'b1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: DUT output with no expected entry", name);
  endtask

  // Monitor: pops expectations whenever the DUT transfers a result or issues a read
  always @(negedge clk) begin
    if (rstn && res_valid && res_ready) begin
      if (exp_res_q.size() == 0) unexpected("res_data");
      else chk("res_data", 256'(res_data), 256'(exp_res_q.pop_front()));
    end
    if (rstn && (a_rd_en || b_rd_en)) begin
      chk("rd_en_pair", 256'(b_rd_en), 256'(a_rd_en));
      if (addr_chk_en) begin
        if (exp_addr_q.size() == 0) unexpected("rd_addr");
        else begin
          logic [19:0] e;
          e = exp_addr_q.pop_front();
          chk("a_addr", 256'(a_addr), 256'(e[19:10]));
          chk("b_addr", 256'(b_addr), 256'(e[9:0]));
        end
      end
    end
  end

  task automatic run_tile(input int k, input int ab, input int bb, input logic [127:0] exp,
                          input int exp_lat, input bit hold);
    int lat = 0;
    int rd  = 0;
    for (int i = 0; i < k; i++) exp_addr_q.push_back({10'(ab + i), 10'(bb + i)});
    exp_res_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b1; k_len = 10'(k); a_base = 10'(ab); b_base = 10'(bb);
    @(posedge clk); #1;
    start = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (a_rd_en) rd++;
    end while (!res_valid && lat < 100);
    chk("latency", 256'(lat), 256'(exp_lat));
    chk("rd_cycles", 256'(rd), 256'(k));
    if (!hold) begin
      @(negedge clk);
      chk("idle_after", 256'({busy, res_valid}), 256'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
    a_mem[0] = {8'd1, 8'd2};  a_mem[1] = {8'd3, 8'd4};  a_mem[1023] = {8'd5, 8'd6};
    b_mem[0] = {8'd3, 8'd4};  b_mem[10] = {8'd1, 8'd1}; b_mem[11] = {8'd2, 8'd2};
    b_mem[12] = {8'd1, 8'd0};

    #3 rstn = 1'b0;
    #1 chk("reset_outputs",
           256'({busy, a_rd_en, b_rd_en, sa_control, res_valid, a_addr, b_addr, sa_act, sa_weight, res_data}),
           256'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    run_tile(1, 0, 0,    {32'd3, 32'd4, 32'd6, 32'd8},    7, 1'b0);
    run_tile(2, 0, 10,   {32'd7, 32'd7, 32'd10, 32'd10},  8, 1'b0);
    run_tile(0, 0, 0,    128'd0,                          2, 1'b0);
    run_tile(3, 1023, 10, {32'd10, 32'd7, 32'd14, 32'd10}, 9, 1'b0);

    // Back-pressure: result must hold and start must be ignored while in OUT
    res_ready = 1'b0;
    run_tile(1, 1, 0, {32'd9, 32'd12, 32'd12, 32'd16}, 7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = ~start; k_len = 10'd7;
      @(negedge clk);
      chk("hold_valid", 256'(res_valid), 256'(1));
      chk("hold_data", 256'(res_data), 256'({32'd9, 32'd12, 32'd12, 32'd16}));
    end
    @(posedge clk); #1;
    start = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    chk("hold_busy", 256'(busy), 256'(1));
    run_tile(2, 0, 10, {32'd7, 32'd7, 32'd10, 32'd10}, 8, 1'b0);

    // Reset in the middle of FEED drops the tile
    addr_chk_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; k_len = 10'd5; a_base = 10'd0; b_base = 10'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_feed_rd_en", 256'(a_rd_en), 256'(1));
    rstn = 1'b0;
    #1 chk("mid_feed_reset",
           256'({busy, a_rd_en, b_rd_en, sa_control, res_valid, a_addr, b_addr, sa_act, sa_weight, res_data}),
           256'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    addr_chk_en = 1'b1;
    run_tile(1, 0, 0, {32'd3, 32'd4, 32'd6, 32'd8}, 7, 1'b0);

    repeat (2) @(negedge clk);
    chk("res_queue_empty", 256'(exp_res_q.size()), 256'(0));
    chk("addr_queue_empty", 256'(exp_addr_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
